// File: rtl/mdu_hilo_pkg.sv
// rtl/mdu_hilo_pkg.sv - HI/LO op encodings and class predicates shared by E stage, stall unit and MDU
package mdu_hilo_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } hilo_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // Multiply class: plain products and the accumulating forms share MULT latency.
  function automatic logic is_mul(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    case (op)
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational product, accumulate, quotient and remainder for the HI/LO unit
module mdu_calc
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn;
  logic [W2-1:0]    rs_ext, rt_ext, product, acc;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag, q_mag, r_mag, quot, rem;

  // Divide works on magnitudes so MIN / -1 wraps to MIN with zero remainder on its own.
  always_comb begin
    sgn     = is_signed(op);
    rs_ext  = sgn ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    rt_ext  = sgn ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    product = rs_ext * rt_ext;
    acc     = {hi, lo};

    rs_neg  = sgn & rs[WIDTH-1];
    rt_neg  = sgn & rt[WIDTH-1];
    rs_mag  = rs_neg ? -rs : rs;
    rt_mag  = rt_neg ? -rt : rt;
    q_mag   = (rt_mag == '0) ? '0 : rs_mag / rt_mag;
    r_mag   = (rt_mag == '0) ? '0 : rs_mag % rt_mag;
    quot    = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
    rem     = rs_neg ? -r_mag : r_mag;

    result = product;
    if (is_acc(op)) begin
      result = is_sub(op) ? acc - product : acc + product;
    end else if (is_div(op)) begin
      result = (rt == '0) ? acc : {rem, quot};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with HI/LO registers for the E stage
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       HILOOp,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic             Req,
  output logic             busy,
  output logic [WIDTH-1:0] HILOOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0]        count, count_next;
  logic [2*WIDTH-1:0]   pending, pending_next, calc_result;
  logic [WIDTH-1:0]     hi_next, lo_next;
  mdu_state_e           state;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (HILOOp),
    .rs     (rsData),
    .rt     (rtData),
    .hi     (hi),
    .lo     (lo),
    .result (calc_result)
  );

  // Next-state: RUN counts down and commits on 1->0; IDLE accepts a start or MT write unless Req.
  always_comb begin
    count_next   = count;
    pending_next = pending;
    hi_next      = hi;
    lo_next      = lo;
    state        = (count == '0) ? S_IDLE : S_RUN;
    case (state)
      S_RUN: begin
        count_next = count - 1'b1;
        if (count == CW'(1)) begin
          {hi_next, lo_next} = pending;
        end
      end
      default: begin
        if (!Req) begin
          if (is_mul(HILOOp)) begin
            pending_next = calc_result;
            count_next   = CW'(MULT_CYCLES);
          end else if (is_div(HILOOp)) begin
            pending_next = calc_result;
            count_next   = CW'(DIV_CYCLES);
          end else if (HILOOp == OP_MTHI) begin
            hi_next = rsData;
          end else if (HILOOp == OP_MTLO) begin
            lo_next = rsData;
          end
        end
      end
    endcase
  end

  // State registers; reset wins over any in-flight operation and drops its commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      count   <= count_next;
      pending <= pending_next;
      hi      <= hi_next;
      lo      <= lo_next;
    end
  end

  assign busy = (count != '0);

  // Zero-latency HI/LO read path for MFHI/MFLO.
  always_comb begin
    HILOOut = '0;
    if (HILOOp == OP_MFHI) begin
      HILOOut = hi;
    end else if (HILOOp == OP_MFLO) begin
      HILOOut = lo;
    end
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. Multi-cycle MULT/DIV (signed and unsigned) with per-class latency, MADD/MSUB accumulation, MTHI/MTLO writes and MFHI/MFLO reads. Drives `busy` to the stall unit and honours the exception request `Req`, so no instruction flushed by an exception modifies HI/LO.

## Interface
- `WIDTH`, 32: operand and HI/LO register width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU. Must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU. Must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `HILOOp`  in  4  operation of the instruction currently in E. Encodings:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO;
  - 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13–15 behave as NONE.
- `rsData`  in  WIDTH  forwarded rs operand.
- `rtData`  in  WIDTH  forwarded rt operand.
- `Req`  in  1  exception/interrupt entry this cycle; suppresses any start or write.
- `busy`  out  1  operation in flight.
- `HILOOut`  out  WIDTH  HI when `HILOOp`=MFHI, LO when MFLO, else 0. Combinational.
- `hi`, `lo`  out  WIDTH  current HI/LO registers.

## Operation
- Reset (reset=0 at an edge):
  - HI=0, LO=0, count=0, busy=0, pending result cleared.
  - Overrides everything, including an in-flight operation.
- Two states, derived from count:
  - IDLE (count==0).
  - RUN (count!=0).
- IDLE, valid op, Req=0:
  - Multiply class: capture 2·WIDTH result; count ← MULT_CYCLES. HI/LO keep old value until commit.
  - Divide class: capture quotient→LO, remainder→HI; count ← DIV_CYCLES.
  - MTHI/MTLO: write rsData to HI/LO at this edge. No busy.
  - MFHI/MFLO: read only, no state change.
- RUN:
  - count decrements each cycle.
  - On the edge where count goes 1→0, commit the pending {HI,LO}.
- Start requests in RUN (any multiply/divide/MTHI/MTLO) are ignored; the stall unit must prevent them.
- Req=1 in IDLE: suppresses the start or MT write of that cycle. An already-running operation is older than the faulting instruction and still completes and commits.
- Arithmetic:
  - Signed ops sign-extend to 2·WIDTH; unsigned ops zero-extend.
  - MULT/MULTU: {HI,LO} = product.
  - MADD/MSUB: {HI,LO} ± product, taken modulo 2^(2·WIDTH), using HI/LO at the start cycle.
  - DIV: quotient truncates toward zero; remainder has the dividend's sign.
  - Divide by zero: full latency, HI/LO unchanged at commit.
  - Signed DIV of MIN by −1: LO=MIN, HI=0.

## Timing
- Start sampled at the edge ending cycle T.
- `busy`=1 for cycles T+1 … T+L (L = MULT_CYCLES or DIV_CYCLES).
- New HI/LO are visible from cycle T+L+1.
- `busy` is registered and never high in cycle T itself. The stall unit stalls on (E op is multiply/divide/MT/MF) && (busy || start in E).
- MTHI/MTLO update is visible in the next cycle.
- `HILOOut` has zero-cycle latency from `HILOOp` and the registers.
- Reset in mid-RUN: busy=0 and HI/LO=0 in the following cycle; no commit.

## Structure
- Op encodings and their class predicates (is_mul, is_div, is_acc, is_signed) go in the shared constant header beside the other pipeline constants. E stage, stall unit and this block share them.
- One natural sub-module, `mdu_calc`: combinational signed/unsigned product, accumulation, quotient and remainder with the edge-case rules above. The top holds the counter, the pending register and HI/LO.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 (defaults):
  - busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=−7, rt=2 → after 10 busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIV by 0 leaves HI/LO unchanged.
  - DIV 0x80000000 by −1 gives LO=0x80000000, HI=0.
- MTHI 0x12345678 with Req=1 → HI unchanged.
  - Next cycle MTHI with Req=0 → HI=0x12345678.
  - MFHI → HILOOut=0x12345678.
- HI=0, LO=0xFFFFFFFF; MADDU rs=1, rt=1 → HI=1, LO=0.
  - MSUB rs=1, rt=1 then gives HI=0, LO=0xFFFFFFFF.
- MULT started, Req=1 in cycle T+2 → commit still occurs at T+6.
  - A DIV issued while busy is ignored.
  - Reset=0 in cycle T+3 of a new MULT → HI=LO=0, busy=0, no later commit.
